control_unit: RTL and testbench

Hardwired Moore control unit for the MiniSRC `datapath`. It fetches instructions, decodes the opcode in `IR_Data[31:27]`, and steps through T0–T7 to drive every datapath strobe: register in/out enables, `Read`/`Write`, `Gra`/`Grb`/`Grc`/`Rin`/`Rout`/`BAout`, `CON_in` and the ALU opcode. It also owns the `run` and `clr` system signals. It sits beside `datapath` in the top level and replaces testbench-driven control.

---
 rtl/minisrc_pkg.sv | 70 +++++++
 rtl/ctrl_decode.sv | 73 +++++++
 rtl/control_unit.sv | 213 +++++++++++++++++++++
 tb/tb_control_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : minisrc_pkg
// Brief    : MiniSRC opcode encodings, control-unit states and opcode classes.
// Revision : 1.0
// ============================================================================
package minisrc_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_T0    = 4'd1,
    ST_T1    = 4'd2,
    ST_T2    = 4'd3,
    ST_T3    = 4'd4,
    ST_T4    = 4'd5,
    ST_T5    = 4'd6,
    ST_T6    = 4'd7,
    ST_T7    = 4'd8,
    ST_HALT  = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_HALT   = 4'd1,
    CLS_ALU3   = 4'd2,
    CLS_IMM    = 4'd3,
    CLS_NEGNOT = 4'd4,
    CLS_LD     = 4'd5,
    CLS_ST     = 4'd6,
    CLS_BR     = 4'd7,
    CLS_JR     = 4'd8,
    CLS_JAL    = 4'd9,
    CLS_IN     = 4'd10,
    CLS_OUT    = 4'd11,
    CLS_MFHI   = 4'd12,
    CLS_MFLO   = 4'd13,
    CLS_MULDIV = 4'd14
  } op_class_e;

endpackage : minisrc_pkg
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational opcode-to-class and ALU operation code mapping.
//            MUL_DIV_EN: when defined, mul/div decode as a real class.
// Revision : 1.0
// ============================================================================
module ctrl_decode
  import minisrc_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class,
  output logic [4:0] alu_code
);

  always_comb begin
    op_class = CLS_NOP;
    alu_code = 5'd0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
        op_class = CLS_ALU3;
        alu_code = opcode;
      end
      OP_ADDI, OP_LDI: begin
        op_class = CLS_IMM;
        alu_code = OP_ADD;
      end
      OP_ANDI: begin
        op_class = CLS_IMM;
        alu_code = OP_AND;
      end
      OP_ORI: begin
        op_class = CLS_IMM;
        alu_code = OP_OR;
      end
      OP_NEG, OP_NOT: begin
        op_class = CLS_NEGNOT;
        alu_code = opcode;
      end
      OP_LD: begin
        op_class = CLS_LD;
        alu_code = OP_ADD;
      end
      OP_ST: begin
        op_class = CLS_ST;
        alu_code = OP_ADD;
      end
      OP_BR: begin
        op_class = CLS_BR;
        alu_code = OP_ADD;
      end
      OP_JR:   op_class = CLS_JR;
      OP_JAL:  op_class = CLS_JAL;
      OP_IN:   op_class = CLS_IN;
      OP_OUT:  op_class = CLS_OUT;
      OP_MFHI: op_class = CLS_MFHI;
      OP_MFLO: op_class = CLS_MFLO;
      OP_HALT: op_class = CLS_HALT;
`ifdef MUL_DIV_EN
      OP_MUL, OP_DIV: begin
        op_class = CLS_MULDIV;
        alu_code = opcode;
      end
`endif
      default: begin
        op_class = CLS_NOP;
        alu_code = 5'd0;
      end
    endcase
  end

endmodule : ctrl_decode
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Hardwired Moore control unit for the MiniSRC datapath (T0-T7).
//            MUL_DIV_EN: when defined, enables the mul/div execute sequence.
// Revision : 1.0
// ============================================================================
module control_unit
  import minisrc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic [31:0] IR_Data,
  input  logic        CON_out,
  output logic        run,
  output logic        clr,
  output logic        PC_in,
  output logic        IR_in,
  output logic        Y_in,
  output logic        Z_in,
  output logic        HI_in,
  output logic        LO_in,
  output logic        MAR_in,
  output logic        MDR_in,
  output logic        OutPort_in,
  output logic        IncPC,
  output logic        PC_out,
  output logic        Zhigh_out,
  output logic        Zlow_out,
  output logic        HI_out,
  output logic        LO_out,
  output logic        MDR_out,
  output logic        InPort_out,
  output logic        C_out,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        CON_in,
  output logic [4:0]  alu_instruction_bits
);

  state_e     r_state;
  state_e     w_state_nxt;
  op_class_e  w_cls;
  logic [4:0] w_alu_code;
  logic       w_is_ldi;
  logic       w_exec;
  logic       w_ir_unused;

  // Only the opcode field steers control; operand fields belong to the datapath.
  assign w_ir_unused = ^IR_Data[26:0];
  assign w_is_ldi    = (IR_Data[31:27] == OP_LDI);

  ctrl_decode u_decode (
    .opcode   (IR_Data[31:27]),
    .op_class (w_cls),
    .alu_code (w_alu_code)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RESET;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RESET: w_state_nxt = ST_T0;
      ST_T0:    w_state_nxt = ST_T1;
      ST_T1:    w_state_nxt = ST_T2;
      ST_T2: begin
        case (w_cls)
          CLS_NOP:  w_state_nxt = ST_T0;
          CLS_HALT: w_state_nxt = ST_HALT;
          default:  w_state_nxt = ST_T3;
        endcase
      end
      ST_T3: begin
        case (w_cls)
          CLS_JR, CLS_IN, CLS_OUT, CLS_MFHI, CLS_MFLO: w_state_nxt = ST_T0;
          default:                                     w_state_nxt = ST_T4;
        endcase
      end
      ST_T4: begin
        case (w_cls)
          CLS_NEGNOT, CLS_JAL: w_state_nxt = ST_T0;
          default:             w_state_nxt = ST_T5;
        endcase
      end
      ST_T5: begin
        case (w_cls)
          CLS_ALU3, CLS_IMM: w_state_nxt = ST_T0;
          default:           w_state_nxt = ST_T6;
        endcase
      end
      ST_T6: begin
        case (w_cls)
          CLS_BR, CLS_MULDIV: w_state_nxt = ST_T0;
          default:            w_state_nxt = ST_T7;
        endcase
      end
      ST_T7:   w_state_nxt = ST_T0;
      ST_HALT: w_state_nxt = ST_HALT;
      default: w_state_nxt = ST_RESET;
    endcase
    // A halt request only takes effect at an instruction boundary.
    if (w_state_nxt == ST_T0 && stop) w_state_nxt = ST_HALT;
  end

  assign w_exec = (r_state == ST_T3) || (r_state == ST_T4) || (r_state == ST_T5) ||
                  (r_state == ST_T6) || (r_state == ST_T7);

  always_comb begin
    PC_in = 1'b0;      IR_in = 1'b0;      Y_in = 1'b0;       Z_in = 1'b0;
    HI_in = 1'b0;      LO_in = 1'b0;      MAR_in = 1'b0;     MDR_in = 1'b0;
    OutPort_in = 1'b0; IncPC = 1'b0;      PC_out = 1'b0;     Zhigh_out = 1'b0;
    Zlow_out = 1'b0;   HI_out = 1'b0;     LO_out = 1'b0;     MDR_out = 1'b0;
    InPort_out = 1'b0; C_out = 1'b0;      Read = 1'b0;       Write = 1'b0;
    Gra = 1'b0;        Grb = 1'b0;        Grc = 1'b0;        Rin = 1'b0;
    Rout = 1'b0;       BAout = 1'b0;      CON_in = 1'b0;
    clr = (r_state == ST_RESET);
    run = (r_state == ST_T0) || (r_state == ST_T1) || (r_state == ST_T2) || w_exec;
    alu_instruction_bits = w_exec ? w_alu_code : 5'd0;

    case (r_state)
      ST_T0: begin
        PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; Z_in = 1'b1;
      end
      ST_T1: begin
        Zlow_out = 1'b1; PC_in = 1'b1; Read = 1'b1; MDR_in = 1'b1;
      end
      ST_T2: begin
        MDR_out = 1'b1; IR_in = 1'b1;
      end
      ST_T3: begin
        case (w_cls)
          CLS_ALU3:   begin Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
          CLS_IMM:    begin Grb = 1'b1; Rout = !w_is_ldi; BAout = w_is_ldi; Y_in = 1'b1; end
          CLS_NEGNOT: begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; end
          CLS_LD,
          CLS_ST:     begin Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; end
          CLS_BR:     begin Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; end
          CLS_JR:     begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
          CLS_JAL:    begin PC_out = 1'b1; Grb = 1'b1; Rin = 1'b1; end
          CLS_IN:     begin InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_OUT:    begin Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1; end
          CLS_MFHI:   begin HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_MFLO:   begin LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin Gra = 1'b1; Rout = 1'b1; Y_in = 1'b1; end
`endif
          default: ;
        endcase
      end
      ST_T4: begin
        case (w_cls)
          CLS_ALU3:   begin Grc = 1'b1; Rout = 1'b1; Z_in = 1'b1; end
          CLS_IMM,
          CLS_LD,
          CLS_ST:     begin C_out = 1'b1; Z_in = 1'b1; end
          CLS_NEGNOT: begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_BR:     begin PC_out = 1'b1; Y_in = 1'b1; end
          CLS_JAL:    begin Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1; end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Z_in = 1'b1; end
`endif
          default: ;
        endcase
      end
      ST_T5: begin
        case (w_cls)
          CLS_ALU3,
          CLS_IMM:    begin Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_LD,
          CLS_ST:     begin Zlow_out = 1'b1; MAR_in = 1'b1; end
          CLS_BR:     begin C_out = 1'b1; Z_in = 1'b1; end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin Zlow_out = 1'b1; LO_in = 1'b1; end
`endif
          default: ;
        endcase
      end
      ST_T6: begin
        case (w_cls)
          CLS_LD:     begin Read = 1'b1; MDR_in = 1'b1; end
          CLS_ST:     begin Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; end
          // CON flip-flop was loaded in T3, so it is settled by now.
          CLS_BR:     begin Zlow_out = 1'b1; PC_in = CON_out; end
`ifdef MUL_DIV_EN
          CLS_MULDIV: begin Zhigh_out = 1'b1; HI_in = 1'b1; end
`endif
          default: ;
        endcase
      end
      ST_T7: begin
        case (w_cls)
          CLS_LD:  begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_ST:  Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule : control_unit
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Self-checking bench for control_unit: directed table, randomized
//            instruction stream against a per-instruction step model, corners.
// Revision : 1.0
// ============================================================================
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset, stop, CON_out;
  logic [31:0] IR_Data;
  logic run, clr, PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
  logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in;
  logic [4:0]  alu_instruction_bits;
  logic [26:0] act;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset(reset), .stop(stop), .IR_Data(IR_Data), .CON_out(CON_out),
    .run(run), .clr(clr), .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in),
    .HI_in(HI_in), .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
    .OutPort_in(OutPort_in), .IncPC(IncPC), .PC_out(PC_out), .Zhigh_out(Zhigh_out),
    .Zlow_out(Zlow_out), .HI_out(HI_out), .LO_out(LO_out), .MDR_out(MDR_out),
    .InPort_out(InPort_out), .C_out(C_out), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .CON_in(CON_in), .alu_instruction_bits(alu_instruction_bits)
  );

  assign act = {CON_in, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, C_out,
                InPort_out, MDR_out, LO_out, HI_out, Zlow_out, Zhigh_out, PC_out,
                IncPC, OutPort_in, MDR_in, MAR_in, LO_in, HI_in, Z_in, Y_in, IR_in, PC_in};

  localparam logic [26:0] PCI = 27'd1 << 0,  IRI = 27'd1 << 1,  YI  = 27'd1 << 2;
  localparam logic [26:0] ZI  = 27'd1 << 3,  HII = 27'd1 << 4,  LOI = 27'd1 << 5;
  localparam logic [26:0] MARI= 27'd1 << 6,  MDRI= 27'd1 << 7,  OPI = 27'd1 << 8;
  localparam logic [26:0] INC = 27'd1 << 9,  PCO = 27'd1 << 10, ZHO = 27'd1 << 11;
  localparam logic [26:0] ZLO = 27'd1 << 12, HIO = 27'd1 << 13, LOO = 27'd1 << 14;
  localparam logic [26:0] MDRO= 27'd1 << 15, IPO = 27'd1 << 16, CO  = 27'd1 << 17;
  localparam logic [26:0] RD  = 27'd1 << 18, WR  = 27'd1 << 19, GRA = 27'd1 << 20;
  localparam logic [26:0] GRB = 27'd1 << 21, GRC = 27'd1 << 22, RIN = 27'd1 << 23;
  localparam logic [26:0] ROUT= 27'd1 << 24, BAO = 27'd1 << 25, CONI= 27'd1 << 26;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [26:0] es, input logic [4:0] ea,
                       input logic er, input logic ec);
    checks++;
    if ({clr, run, alu_instruction_bits, act} !== {ec, er, ea, es}) begin
      failures++;
      $display("FAIL %s: got clr=%0b run=%0b alu=%05b strb=%07h, expected clr=%0b run=%0b alu=%05b strb=%07h",
               name, clr, run, alu_instruction_bits, act, ec, er, ea, es);
    end
  endtask

  // Reference: full per-step strobe list of one instruction, from the opcode table.
  logic [26:0] m_seq [8];
  int          m_len;
  logic [4:0]  m_alu;
  bit          m_halts;

  task automatic model(input logic [4:0] op, input bit con);
    for (int i = 0; i < 8; i++) m_seq[i] = '0;
    m_seq[0] = PCO | MARI | INC | ZI;
    m_seq[1] = ZLO | PCI | RD | MDRI;
    m_seq[2] = MDRO | IRI;
    m_len = 3; m_alu = 5'd0; m_halts = 1'b0;
    if (op >= 5'd3 && op <= 5'd11) begin
      m_seq[3] = GRB | ROUT | YI; m_seq[4] = GRC | ROUT | ZI; m_seq[5] = ZLO | GRA | RIN;
      m_len = 6; m_alu = op;
    end else if (op == 5'd1 || (op >= 5'd12 && op <= 5'd14)) begin
      m_seq[3] = GRB | YI | ((op == 5'd1) ? BAO : ROUT);
      m_seq[4] = CO | ZI; m_seq[5] = ZLO | GRA | RIN;
      m_len = 6; m_alu = (op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 : 5'd3;
    end else if (op == 5'd17 || op == 5'd18) begin
      m_seq[3] = GRB | ROUT | ZI; m_seq[4] = ZLO | GRA | RIN; m_len = 5; m_alu = op;
    end else if (op == 5'd0 || op == 5'd2) begin
      m_seq[3] = GRB | BAO | YI; m_seq[4] = CO | ZI; m_seq[5] = ZLO | MARI;
      m_seq[6] = (op == 5'd0) ? (RD | MDRI) : (GRA | ROUT | MDRI);
      m_seq[7] = (op == 5'd0) ? (MDRO | GRA | RIN) : WR;
      m_len = 8; m_alu = 5'd3;
    end else if (op == 5'd19) begin
      m_seq[3] = GRA | ROUT | CONI; m_seq[4] = PCO | YI; m_seq[5] = CO | ZI;
      m_seq[6] = ZLO | (con ? PCI : 27'd0); m_len = 7; m_alu = 5'd3;
    end else if (op == 5'd20) begin
      m_seq[3] = GRA | ROUT | PCI; m_len = 4;
    end else if (op == 5'd21) begin
      m_seq[3] = PCO | GRB | RIN; m_seq[4] = GRA | ROUT | PCI; m_len = 5;
    end else if (op >= 5'd22 && op <= 5'd25) begin
      case (op)
        5'd22:   m_seq[3] = IPO | GRA | RIN;
        5'd23:   m_seq[3] = GRA | ROUT | OPI;
        5'd24:   m_seq[3] = HIO | GRA | RIN;
        default: m_seq[3] = LOO | GRA | RIN;
      endcase
      m_len = 4;
    end else if (op == 5'd15 || op == 5'd16) begin
`ifdef MUL_DIV_EN
      m_seq[3] = GRA | ROUT | YI; m_seq[4] = GRB | ROUT | ZI;
      m_seq[5] = ZLO | LOI; m_seq[6] = ZHO | HII; m_len = 7; m_alu = op;
`endif
    end else if (op == 5'd27) begin
      m_halts = 1'b1;
    end
  endtask

  typedef struct {
    logic [31:0] ir;
    bit          con;
    int          cycles;
    int          step;
    logic [26:0] strb;
    logic [4:0]  alu;
  } vec_t;

  vec_t vt [14];

  task automatic run_vec(input int i);
    @(posedge clk); #1;
    IR_Data = vt[i].ir; CON_out = vt[i].con;
    for (int s = 0; s < vt[i].cycles; s++) begin
      @(negedge clk);
      if (s == vt[i].step) check($sformatf("vec%0d", i), vt[i].strb, vt[i].alu, 1'b1, 1'b0);
    end
  endtask

  // One instruction against the model; random stop pulses mid-instruction must be ignored.
  task automatic run_rand(input logic [4:0] op, input bit con, input bit final_stop);
    logic [31:0] r;
    @(posedge clk); #1;
    r = $urandom;
    IR_Data = {op, r[26:0]}; CON_out = con;
    model(op, con);
    for (int s = 0; s < m_len; s++) begin
      @(negedge clk);
      check($sformatf("rand_op%0d_s%0d", op, s), m_seq[s], (s >= 3) ? m_alu : 5'd0, 1'b1, 1'b0);
      stop = (s < m_len - 1) ? 1'($urandom_range(0, 1)) : final_stop;
    end
  endtask

  task automatic halt_check(input string name);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check(name, 27'd0, 5'd0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; stop = 1'b0;
    #1 check("reset_hold", 27'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vt[0]  = '{32'h18918000, 1'b0, 6, 0, PCO | MARI | INC | ZI, 5'd0};
    vt[1]  = '{32'h18918000, 1'b0, 6, 3, GRB | ROUT | YI, 5'b00011};
    vt[2]  = '{32'h18918000, 1'b0, 6, 4, GRC | ROUT | ZI, 5'b00011};
    vt[3]  = '{32'h18918000, 1'b0, 6, 5, ZLO | GRA | RIN, 5'b00011};
    vt[4]  = '{32'h09000005, 1'b0, 6, 3, GRB | BAO | YI, 5'b00011};
    vt[5]  = '{32'h09000005, 1'b0, 6, 4, CO | ZI, 5'b00011};
    vt[6]  = '{32'h09000005, 1'b0, 6, 5, ZLO | GRA | RIN, 5'b00011};
    vt[7]  = '{32'h98000000, 1'b0, 7, 6, ZLO, 5'b00011};
    vt[8]  = '{32'h98000000, 1'b1, 7, 6, ZLO | PCI, 5'b00011};
`ifdef MUL_DIV_EN
    vt[9]  = '{32'h78000000, 1'b0, 7, 5, ZLO | LOI, 5'b01111};
    vt[10] = '{32'h78000000, 1'b0, 7, 6, ZHO | HII, 5'b01111};
`else
    vt[9]  = '{32'h78000000, 1'b0, 3, 2, MDRO | IRI, 5'd0};
    vt[10] = '{32'h78000000, 1'b0, 3, 1, ZLO | PCI | RD | MDRI, 5'd0};
`endif
    vt[11] = '{32'hD0000000, 1'b0, 3, 2, MDRO | IRI, 5'd0};
    vt[12] = '{32'h68000000, 1'b0, 6, 4, CO | ZI, 5'b00101};
    vt[13] = '{32'hA8000000, 1'b0, 5, 3, PCO | GRB | RIN, 5'd0};

    reset = 1'b0; stop = 1'b0; CON_out = 1'b0; IR_Data = 32'h18918000;
    repeat (2) @(negedge clk);
    check("reset_state", 27'd0, 5'd0, 1'b0, 1'b1);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(i);

    for (int n = 0; n < 150; n++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd3;
      run_rand(op, 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset pulled during ld T6 (Read high): strobes drop without waiting for a clock edge.
    @(posedge clk); #1;
    IR_Data = 32'h00000000;
    model(5'd0, 1'b0);
    for (int s = 0; s < 7; s++) begin
      @(negedge clk);
      check($sformatf("ld_s%0d", s), m_seq[s], (s >= 3) ? m_alu : 5'd0, 1'b1, 1'b0);
    end
    #1 reset = 1'b0;
    #1 check("rst_mid_ld", 27'd0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_mid_ld_hold", 27'd0, 5'd0, 1'b0, 1'b1);
    reset = 1'b1;
    run_rand(5'd3, 1'b0, 1'b0);

    // halt opcode
    run_rand(5'd27, 1'b0, 1'b0);
    halt_check("halt_opcode");
    do_reset();

    // stop at instruction boundary
    run_rand(5'd5, 1'b0, 1'b1);
    halt_check("halt_stop");
    do_reset();
    run_rand(5'd19, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule : tb_control_unit
`default_nettype wire
